motor_cmd_uart_tx: RTL



---
 rtl/motor_cmd_pkg.sv | 18 +
 rtl/motor_cmd_uart_tx_if.sv | 13 +
 rtl/uart_byte_tx.sv | 62 ++++++
 rtl/motor_cmd_uart_tx.sv | 79 +++++++
 4 files changed

// File: rtl/motor_cmd_pkg.sv
// motor_cmd_pkg: shared TX state type, framing constants and one-hot to command-code encoder
package motor_cmd_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
  localparam int DATA_BITS = 8;
  localparam int PKT_BYTES = 2;
  function automatic logic [7:0] onehot_to_code(input logic [15:0] state, input logic [7:0] base, input logic [7:0] stop);
    logic [7:0] code;
    int n;
    code = stop;
    n = 0;
    for (int i = 0; i < 16; i++)
      if (state[i]) begin
        n++;
        code = base + 8'(i);
      end
    return n == 1 ? code : stop;
  endfunction
endpackage

// File: rtl/motor_cmd_uart_tx_if.sv
// motor_cmd_uart_tx_if: motor command in; UART line, busy, fifo_count and overflow out
interface motor_cmd_uart_tx_if #(
  parameter int STATE_W = 5,
  parameter int FIFO_DEPTH = 4
);
  logic [STATE_W-1:0] motor_state;
  logic uart_out;
  logic busy;
  logic overflow;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  modport master (output motor_state, input uart_out, busy, fifo_count, overflow);
  modport slave (input motor_state, output uart_out, busy, fifo_count, overflow);
endinterface

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: serialises one byte per valid/ready handshake as start, 8 data LSB first, [parity], stop bits
// Ports: clk, rst; data/valid in, ready out (high in IDLE and on the last stop cycle so bytes chain gap-free);
// tx line out (idles high); busy out (not IDLE). Optional even parity bit with MOTOR_CMD_PARITY_EN.
module uart_byte_tx import motor_cmd_pkg::*; #(
  parameter int CLKS_PER_BIT = 434,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx,
  output logic       busy
);
  localparam int CW = $clog2(STOP_BITS * CLKS_PER_BIT);
  tx_state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic [7:0] sh;
  logic bit_end, stop_end;
  assign bit_end = cnt == CW'(CLKS_PER_BIT - 1);
  assign stop_end = cnt == CW'(STOP_BITS * CLKS_PER_BIT - 1);
  assign ready = state == IDLE || (state == STOP && stop_end);
  assign busy = state != IDLE;
`ifdef MOTOR_CMD_PARITY_EN
  logic par;
  assign tx = state == START ? 1'b0 : state == DATA ? sh[0] : state == PARITY ? par : 1'b1;
  always_ff @(posedge clk)
    if (rst) par <= 1'b0;
    else if (ready && valid) par <= ^data;
`else
  assign tx = state == START ? 1'b0 : state == DATA ? sh[0] : 1'b1;
`endif
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = valid ? START : IDLE;
      START:   state_n = bit_end ? DATA : START;
`ifdef MOTOR_CMD_PARITY_EN
      DATA:    state_n = bit_end && idx == 3'(DATA_BITS - 1) ? PARITY : DATA;
      PARITY:  state_n = bit_end ? STOP : PARITY;
`else
      DATA:    state_n = bit_end && idx == 3'(DATA_BITS - 1) ? STOP : DATA;
`endif
      STOP:    state_n = stop_end ? (valid ? START : IDLE) : STOP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
    end else begin
      state <= state_n;
      cnt <= (state == IDLE || (state == STOP ? stop_end : bit_end)) ? '0 : cnt + 1'b1;
      idx <= ready ? '0 : (state == DATA && bit_end) ? idx + 1'b1 : idx;
      sh <= (ready && valid) ? data : (state == DATA && bit_end) ? sh >> 1 : sh;
    end
endmodule

// File: rtl/motor_cmd_uart_tx.sv
// motor_cmd_uart_tx: encodes a one-hot motor command into header+code UART packets via a small FIFO
// Ports: CLOCK_50, reset (sync, active high); bus.motor_state in; bus.uart_out, bus.busy,
// bus.fifo_count, bus.overflow (sticky) out. Define MOTOR_CMD_PARITY_EN for an even parity bit per byte.
module motor_cmd_uart_tx import motor_cmd_pkg::*; #(
  parameter int         STATE_W      = 5,
  parameter int         CLKS_PER_BIT = 434,
  parameter int         STOP_BITS    = 1,
  parameter logic [7:0] HDR_BYTE     = 8'hA5,
  parameter logic [7:0] CMD_BASE     = 8'h30,
  parameter logic [7:0] STOP_CODE    = 8'h00,
  parameter int         FIFO_DEPTH   = 4,
  parameter int         REFRESH_CYC  = 0
) (
  input logic CLOCK_50,
  input logic reset,
  motor_cmd_uart_tx_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int RW = REFRESH_CYC > 1 ? $clog2(REFRESH_CYC) : 1;
  localparam int BW = $clog2(PKT_BYTES);
  logic [STATE_W-1:0] s1;
  logic [7:0] code, last_code, push_data, code_q, tx_data;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] count;
  logic [RW-1:0] rcnt;
  logic [BW-1:0] byte_idx;
  logic change, refresh, push, full, pop, wr, tx_valid, tx_ready, tx_busy, overflow;
  assign code = onehot_to_code(16'(s1), CMD_BASE, STOP_CODE);
  assign change = code != last_code;
  assign refresh = REFRESH_CYC > 0 && rcnt == RW'(REFRESH_CYC - 1);
  // a change wins over a coincident refresh, so only the new code is queued
  assign push = change || refresh;
  assign push_data = change ? code : last_code;
  assign full = count == (AW + 1)'(FIFO_DEPTH);
  assign tx_valid = byte_idx != '0 || count != '0;
  assign pop = tx_ready && tx_valid && byte_idx == '0;
  assign wr = push && (!full || pop);
  assign tx_data = byte_idx == '0 ? HDR_BYTE : code_q;
  assign bus.busy = tx_busy || count != '0;
  assign bus.fifo_count = count;
  assign bus.overflow = overflow;
  always_ff @(posedge CLOCK_50)
    if (reset) begin
      s1 <= '0;
      last_code <= STOP_CODE;
      code_q <= '0;
      wp <= '0;
      rp <= '0;
      count <= '0;
      rcnt <= '0;
      byte_idx <= '0;
      overflow <= 1'b0;
    end else begin
      s1 <= bus.motor_state;
      if (change) last_code <= code;
      rcnt <= push ? '0 : rcnt + 1'b1;
      if (wr) begin
        mem[wp] <= push_data;
        wp <= wp + 1'b1;
      end
      if (pop) begin
        code_q <= mem[rp];
        rp <= rp + 1'b1;
      end
      count <= count + (AW + 1)'(wr) - (AW + 1)'(pop);
      if (push && !wr) overflow <= 1'b1;
      if (tx_ready && tx_valid) byte_idx <= byte_idx == BW'(PKT_BYTES - 1) ? '0 : byte_idx + 1'b1;
    end
  uart_byte_tx #(.CLKS_PER_BIT(CLKS_PER_BIT), .STOP_BITS(STOP_BITS)) u_tx (
    .clk(CLOCK_50),
    .rst(reset),
    .data(tx_data),
    .valid(tx_valid),
    .ready(tx_ready),
    .tx(bus.uart_out),
    .busy(tx_busy)
  );
endmodule
